// File: rtl/riscv_dmi_arbiter.sv
// riscv_dmi_arbiter: N:1 DMI arbiter sharing one riscv_dm request/response port.
// Round-robin request grant, a registered request slot toward the DM, and an
// in-order tag FIFO that returns each DM response to its issuing channel.
// Optional response timeout: define RISCV_DMI_ARB_TIMEOUT_EN to enable it.
module riscv_dmi_arbiter #(
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 7,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OP_WIDTH        = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NUM_CHANNELS-1:0]                  ch_req_valid_i,
    output logic [NUM_CHANNELS-1:0]                  ch_req_ready_o,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  ch_req_addr_i,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  ch_req_data_i,
    input  logic [NUM_CHANNELS-1:0][OP_WIDTH-1:0]    ch_req_op_i,
    output logic [NUM_CHANNELS-1:0]                  ch_resp_valid_o,
    input  logic [NUM_CHANNELS-1:0]                  ch_resp_ready_i,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  ch_resp_data_o,
    output logic [NUM_CHANNELS-1:0][OP_WIDTH-1:0]    ch_resp_op_o,
    output logic                                     dm_req_valid_o,
    input  logic                                     dm_req_ready_i,
    output logic [ADDR_WIDTH-1:0]                    dm_req_addr_o,
    output logic [DATA_WIDTH-1:0]                    dm_req_data_o,
    output logic [OP_WIDTH-1:0]                      dm_req_op_o,
    input  logic                                     dm_resp_valid_i,
    output logic                                     dm_resp_ready_o,
    input  logic [DATA_WIDTH-1:0]                    dm_resp_data_i,
    input  logic [OP_WIDTH-1:0]                      dm_resp_op_i,
    output logic                                     spurious_o
);

    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OP_WIDTH-1:0] OP_FAILED = OP_WIDTH'(2);

    if (NUM_CHANNELS < 1 || MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("riscv_dmi_arbiter: invalid parameter value");
    end

    logic                  slot_valid;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic [DATA_WIDTH-1:0] slot_data;
    logic [OP_WIDTH-1:0]   slot_op;

    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       grant;
    logic                  grant_valid;

    logic [CH_W-1:0]       tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      drop_count;
    logic [CNT_W:0]        occ_sum;
    logic                  fifo_empty;
    logic [CH_W-1:0]       head;

    logic                  can_accept;
    logic                  req_fire;
    logic                  resp_pop;
    logic                  synth_active;
    logic                  spurious_hit;
    logic                  spurious_q;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [OP_WIDTH-1:0]   resp_op;

    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];
    assign occ_sum    = {1'b0, count} + {1'b0, drop_count};

    // Round-robin search for the first valid channel starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!grant_valid && ch_req_valid_i[CH_W'(idx)]) begin
                grant_valid = 1'b1;
                grant       = CH_W'(idx);
            end
        end
    end

    // Occupancy is taken before any same-cycle pop, so a pop never frees space early.
    assign can_accept = !rst_i && (!slot_valid || dm_req_ready_i) &&
                        (occ_sum < (CNT_W + 1)'(MAX_OUTSTANDING));
    assign req_fire   = grant_valid && can_accept;

    // Only the granted channel sees ready.
    always_comb begin
        ch_req_ready_o = '0;
        if (grant_valid) ch_req_ready_o[grant] = can_accept;
    end

    // Response routing: synthetic failure, drop of late responses, spurious discard, or normal route.
    always_comb begin
        ch_resp_valid_o = '0;
        dm_resp_ready_o = 1'b0;
        resp_data       = dm_resp_data_i;
        resp_op         = dm_resp_op_i;
        spurious_hit    = 1'b0;
        if (synth_active) begin
            ch_resp_valid_o[head] = !rst_i;
            resp_data             = '0;
            resp_op               = OP_FAILED;
        end else if (drop_count != '0) begin
            dm_resp_ready_o = 1'b1;
        end else if (fifo_empty) begin
            dm_resp_ready_o = 1'b1;
            spurious_hit    = dm_resp_valid_i;
        end else begin
            ch_resp_valid_o[head] = dm_resp_valid_i && !rst_i;
            dm_resp_ready_o       = ch_resp_ready_i[head];
        end
    end

    assign resp_pop       = |(ch_resp_valid_o & ch_resp_ready_i);
    assign ch_resp_data_o = {NUM_CHANNELS{resp_data}};
    assign ch_resp_op_o   = {NUM_CHANNELS{resp_op}};

    // Request slot: load on a channel handshake, empty when the DM takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            slot_op    <= '0;
        end else if (req_fire) begin
            slot_valid <= 1'b1;
            slot_addr  <= ch_req_addr_i[grant];
            slot_data  <= ch_req_data_i[grant];
            slot_op    <= ch_req_op_i[grant];
        end else if (dm_req_ready_i) begin
            slot_valid <= 1'b0;
        end
    end

    assign dm_req_valid_o = slot_valid;
    assign dm_req_addr_o  = slot_addr;
    assign dm_req_data_o  = slot_data;
    assign dm_req_op_o    = slot_op;

    // Round-robin pointer moves past the winner on each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (req_fire) begin
            rr_ptr <= (grant == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (req_fire) wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            if (resp_pop) rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            case ({req_fire, resp_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (req_fire) tag_mem[wr_ptr] <= grant;
    end

    // Sticky flag for a DM response that nobody asked for.
    always_ff @(posedge clk_i) begin
        if (rst_i) spurious_q <= 1'b0;
        else if (spurious_hit) spurious_q <= 1'b1;
    end

    assign spurious_o = spurious_q;

`ifdef RISCV_DMI_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer;
    logic             drop_consume;

    assign synth_active = !fifo_empty && (timer == TMR_W'(TIMEOUT_CYCLES));
    assign drop_consume = (drop_count != '0) && !synth_active && dm_resp_valid_i;

    // Age of the head request; holds at the limit while the synthetic response waits.
    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_empty || resp_pop) timer <= '0;
        else if (!synth_active) timer <= timer + 1'b1;
    end

    // Late DM responses owed for requests already answered synthetically.
    always_ff @(posedge clk_i) begin
        if (rst_i) drop_count <= '0;
        else if (synth_active && resp_pop) drop_count <= drop_count + 1'b1;
        else if (drop_consume) drop_count <= drop_count - 1'b1;
    end
`else
    assign synth_active = 1'b0;
    assign drop_count   = '0;
`endif

endmodule

// File: doc/riscv_dmi_arbiter.md
Name: riscv_dmi_arbiter

Overview:
- Single-clock N:1 DMI arbiter that lets several debug transports share one riscv_dm request/response port. Example transports: the JTAG DTM after its CDC, and a memory-mapped DMI bridge.
- Round-robin request arbitration, a registered request slot, and an in-order tag FIFO. Responses return to the channel that issued each request.
- Sits between transport CDCs and riscv_dm. Generalises the single-channel DTM-to-DM link to NUM_CHANNELS channels with multiple outstanding requests.

Parameters:
- NUM_CHANNELS, 2, number of requesting DMI channels (>=1)
- MAX_OUTSTANDING, 2, maximum requests issued to the DM and not yet answered (>=1)
- ADDR_WIDTH, 7, DMI address width
- DATA_WIDTH, 32, DMI data width
- OP_WIDTH, 2, DMI op/status width
- TIMEOUT_CYCLES, 1024, response timeout; used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- ch_req_valid_i  in  [NUM_CHANNELS]  per-channel request valid
- ch_req_ready_o  out  [NUM_CHANNELS]  per-channel request ready
- ch_req_addr_i  in  [NUM_CHANNELS][ADDR_WIDTH]  request address
- ch_req_data_i  in  [NUM_CHANNELS][DATA_WIDTH]  request data
- ch_req_op_i  in  [NUM_CHANNELS][OP_WIDTH]  request op
- ch_resp_valid_o  out  [NUM_CHANNELS]  per-channel response valid
- ch_resp_ready_i  in  [NUM_CHANNELS]  per-channel response ready
- ch_resp_data_o  out  [NUM_CHANNELS][DATA_WIDTH]  response data (broadcast)
- ch_resp_op_o  out  [NUM_CHANNELS][OP_WIDTH]  response op (broadcast)
- dm_req_valid_o / dm_req_ready_i  out/in  1  request handshake to the DM
- dm_req_addr_o / dm_req_data_o / dm_req_op_o  out  ADDR/DATA/OP_WIDTH  request payload to the DM
- dm_resp_valid_i / dm_resp_ready_o  in/out  1  response handshake from the DM
- dm_resp_data_i / dm_resp_op_i  in  DATA/OP_WIDTH  response payload from the DM
- spurious_o  out  1  sticky flag: a DM response arrived with no request outstanding

Behaviour:
- Reset, synchronous: all of the following clear to 0.
  - Request slot empty; dm_req_valid_o=0; dm_req_* payload=0.
  - Tag FIFO empty.
  - RR pointer=0.
  - spurious_o=0.
  - All ch_req_ready_o and ch_resp_valid_o=0.
  - Drop counter and timer cleared.
- Handshakes: valid/ready throughout.
  - A valid must never depend on ready.
  - Payload is held stable while valid is high and ready is low.
- Accept condition, `can_accept`: slot empty or draining this cycle (dm_req_valid_o & dm_req_ready_i), AND occupancy+drop_count < MAX_OUTSTANDING.
  - Occupancy is the value before any same-cycle pop; a same-cycle pop does not free space.
- Arbitration:
  - Grant g = first asserted ch_req_valid_i searching from RR pointer upward, with wrap.
  - ch_req_ready_o[g] = can_accept; all other readies are 0.
  - On a handshake: payload is registered into the slot, g is pushed into the tag FIFO, and the RR pointer becomes (g+1) mod NUM_CHANNELS.
  - The pointer is unchanged when there is no grant.
- Latency: channel handshake in cycle N gives dm_req_valid_o=1 in cycle N+1.
  - Back-to-back throughput is one request per cycle while the DM is ready and the FIFO has space.
- All ops, including nop (0), are forwarded unchanged.
- Response routing is combinational.
  - h = FIFO head.
  - ch_resp_valid_o[h] = dm_resp_valid_i & !empty; all other ch_resp_valid_o are 0.
  - dm_resp_ready_o = ch_resp_ready_i[h].
  - Data and op pass through to every channel.
  - A handshake pops the FIFO.
- Spurious response (dm_resp_valid_i while the FIFO is empty and drop_count=0):
  - dm_resp_ready_o=1; the response is discarded.
  - spurious_o sets and holds until reset.
- Simultaneous push and pop: both take effect, and occupancy is unchanged.
- Mid-operation reset: everything in flight is discarded; no responses are produced for pre-reset requests.

Optional Feature:
- Macro: RISCV_DMI_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs while the FIFO is non-empty.
  - It clears on each response pop or when the FIFO is empty.
  - On reaching TIMEOUT_CYCLES, the head channel gets a synthetic response: op=2 (failed), data=0.
    - It is held until that channel's ch_resp_ready_i, then the FIFO pops and drop_count increments.
    - During this, dm_resp_ready_o=0.
  - While drop_count>0, DM responses are consumed with ready=1, not routed, and drop_count decrements per response.
  - Responses dropped this way do not set spurious_o.
- When undefined: no counter; drop_count is tied to 0; the block waits indefinitely for DM responses.

Test Plan:
- Single channel: ch0 sends addr=0x10, data=0x1, op=2 → dm_req_valid_o in the next cycle with identical payload. DM responds data=0xABCD, op=0 → ch_resp_valid_o[0]=1 with data=0xABCD.
- Contention, NUM_CHANNELS=2, both valid continuously, DM always ready → grants alternate 0,1,0,1. Each response goes only to its issuing channel.
- Backpressure: dm_req_ready_i=0 for 5 cycles → dm_req_* stable, ch_req_ready_o=0 once the slot is full. With MAX_OUTSTANDING=2 and no responses, the third request stays blocked.
- Response backpressure: ch_resp_ready_i[1]=0 with ch1 at head → dm_resp_ready_o=0 and the FIFO head is held; releasing it pops.
- Spurious: dm_resp_valid_i=1 with nothing outstanding → dm_resp_ready_o=1, spurious_o=1 until rst_i.
- With RISCV_DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no DM response for 8 cycles → ch0 receives op=2, data=0. A late DM response 3 cycles later is dropped, no channel sees valid, and spurious_o stays 0.
